fp_mul_link_host: RTL and testbench



---
 rtl/fp_mul_link_host_if.sv | 22 ++
 rtl/fp_mul_link_host.sv | 173 +++++++++++++++++
 tb/tb_fp_mul_link_host.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_link_host_if.sv
// Request/response handshake bundle between the system side and the FP_MUL link host.
// The master issues operand requests and consumes products; the host is the slave.
interface fp_mul_link_host_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, op_a, op_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, op_a, op_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/fp_mul_link_host.sv
// Host end of the byte-serial FP_MUL chip link: serialises two doubles as a 16-byte
// ENABLE burst, collects the 8-byte READY burst and returns the product with an error flag.
module fp_mul_link_host #(
    parameter int TIMEOUT    = 255,
    parameter int GAP_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    fp_mul_link_host_if.slave host,
    output logic              ENABLE,
    output logic [7:0]        LINK_DATA,
    input  logic              READY,
    input  logic [7:0]        LINK_IN,
    output logic [2:0]        dbg_state
);

    // TIMEOUT is assumed to be at least 1.
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_RECV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [TW-1:0]  to_q, to_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   sreg_q, sreg_d;
    logic           req_ready_q, req_ready_d;
    logic           enable_q, enable_d;
    logic [7:0]     link_data_q, link_data_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [63:0]    rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;

    // Handshakes: a transfer happens on a rising CLK edge where valid and ready are both
    // high; valid and its payload hold until that edge, and ready may depend on nothing
    // but registered state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            gap_q       <= GAP_LOAD;
            to_q        <= '0;
            cnt_q       <= '0;
            sreg_q      <= '0;
            req_ready_q <= 1'b0;
            enable_q    <= 1'b0;
            link_data_q <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 64'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            to_q        <= to_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            req_ready_q <= req_ready_d;
            enable_q    <= enable_d;
            link_data_q <= link_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        to_d        = to_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        req_ready_d = 1'b0;
        enable_d    = 1'b0;
        link_data_d = 8'h00;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (host.req_valid && req_ready_q) begin
                    sreg_d      = {host.op_b, host.op_a};
                    cnt_d       = 4'd0;
                    enable_d    = 1'b1;
                    link_data_d = host.op_a[7:0];
                    state_d     = S_SEND;
                end else begin
                    if (gap_q != '0) begin
                        gap_d = gap_q - GW'(1);
                    end
                    req_ready_d = (gap_d == '0);
                end
            end

            // sreg_q[7:0] is the byte currently on LINK_DATA; the burst never pauses
            // because the chip's byte index advances on its own.
            S_SEND: begin
                if (cnt_q == 4'd15) begin
                    to_d    = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d       = cnt_q + 4'd1;
                    sreg_d      = sreg_q >> 8;
                    enable_d    = 1'b1;
                    link_data_d = sreg_q[15:8];
                end
            end

            S_WAIT: begin
                to_d = to_q + TW'(1);
                if (READY) begin
                    sreg_d[63:0] = {LINK_IN, 56'h0};
                    cnt_d        = 4'd1;
                    state_d      = S_RECV;
                end else if (to_d == TO_LIMIT) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 64'h0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_DONE;
                end
            end

            // Result bytes shift in from the top so byte 0 lands in [7:0] after eight.
            S_RECV: begin
                if (READY) begin
                    sreg_d[63:0] = {LINK_IN, sreg_q[63:8]};
                    if (cnt_q == 4'd7) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = {LINK_IN, sreg_q[63:8]};
                        rsp_err_d   = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 64'h0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                if (rsp_valid_q && host.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    gap_d       = GAP_LOAD;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign host.req_ready = req_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_err   = rsp_err_q;
    assign ENABLE         = enable_q;
    assign LINK_DATA      = link_data_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fp_mul_link_host.sv
// Randomised bench for fp_mul_link_host: a behavioural FP_MUL chip on the link side and a
// product scoreboard on the response side.
module tb_fp_mul_link_host;

    localparam int TIMEOUT  = 20;
    localparam int GAP      = 2;
    localparam int M_OK     = 0;
    localparam int M_NEVER  = 1;
    localparam int M_BROKEN = 2;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        int          mode;
        int          dly;
        int          blen;
    } txn_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic [7:0]  LINK_DATA;
    logic        READY;
    logic [7:0]  LINK_IN;
    logic [2:0]  dbg_state;

    fp_mul_link_host_if host();

    fp_mul_link_host #(.TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .host      (host),
        .ENABLE    (ENABLE),
        .LINK_DATA (LINK_DATA),
        .READY     (READY),
        .LINK_IN   (LINK_IN),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad = 0;
    int          rsp_cnt = 0;
    int          hs_cyc = -100;
    bit          rand_bp = 1'b0;
    logic [64:0] exp_q[$];
    int          exp_mode_q[$];
    txn_t        sent_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: the chip multiplies two IEEE doubles.
    function automatic logic [63:0] ref_prod(input logic [63:0] a, input logic [63:0] b);
        real ra;
        real rb;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        return $realtobits(ra * rb);
    endfunction

    function automatic logic [63:0] rand_double();
        return {1'($urandom_range(0, 1)), 11'($urandom_range(1000, 1046)), 32'($urandom), 20'($urandom)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [63:0] a, input logic [63:0] b, input int mode,
                            input int dly, input int blen, input bit want,
                            input logic [64:0] exp_v, input bit hold);
        txn_t t;
        int   k;
        k = 0;
        @(posedge CLK); #1;
        host.req_valid = 1'b1;
        host.op_a      = a;
        host.op_b      = b;
        while (k < 300) begin
            @(negedge CLK);
            if (host.req_ready) break;
            k++;
        end
        if (!host.req_ready) begin
            check("req_accept", host.req_ready, 1);
            host.req_valid = 1'b0;
        end else begin
            @(posedge CLK); #1;
            t.a = a; t.b = b; t.mode = mode; t.dly = dly; t.blen = blen;
            sent_q.push_back(t);
            if (want) begin
                exp_q.push_back(exp_v);
                exp_mode_q.push_back(mode);
            end
            if (!hold) host.req_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (rsp_cnt < target) check("rsp_wait", rsp_cnt, target);
    endtask

    task automatic run_txn(input int mode, input int dly, input int blen);
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] e;
        int          n0;
        a  = rand_double();
        b  = rand_double();
        e  = (mode == M_OK) ? {1'b0, ref_prod(a, b)} : {1'b1, 64'h0};
        n0 = rsp_cnt;
        send_req(a, b, mode, dly, blen, 1'b1, e, 1'b0);
        wait_rsp(n0 + 1);
    endtask

    // ---------------- chip model ----------------
    initial begin
        txn_t         cur;
        logic [127:0] cap;
        logic [63:0]  res;
        int           cap_idx, oidx, dly, left, cmode;
        bit           busy, rdy;
        cap = '0; res = '0; cap_idx = 0; oidx = 0; dly = 0; left = 0; cmode = M_OK;
        busy = 1'b0; rdy = 1'b0;
        READY = 1'b0;
        LINK_IN = 8'h00;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                cap_idx = 0; busy = 1'b0; rdy = 1'b0;
                sent_q.delete();
            end else if (ENABLE) begin
                rdy = 1'b0; busy = 1'b0;
                cap[8*cap_idx +: 8] = LINK_DATA;
                if (cap_idx == 15) begin
                    cap_idx = 0;
                    if (sent_q.size() == 0) begin
                        check("chip_burst_owner", sent_q.size(), 1);
                    end else begin
                        cur = sent_q.pop_front();
                        check("link_bytes", cap, {cur.b, cur.a});
                        res   = ref_prod(cap[63:0], cap[127:64]);
                        cmode = cur.mode; dly = cur.dly; left = cur.blen;
                        busy  = 1'b1;
                    end
                end else begin
                    cap_idx++;
                end
            end else if (busy) begin
                if (dly > 0) dly--;
                else begin
                    busy = 1'b0;
                    if (cmode != M_NEVER) begin
                        rdy = 1'b1; oidx = 0;
                    end
                end
            end else if (rdy) begin
                oidx = (oidx + 1) % 8;
                if (cmode == M_BROKEN) begin
                    left--;
                    if (left == 0) rdy = 1'b0;
                end
            end
            @(posedge CLK); #1;
            READY   = rdy;
            LINK_IN = rdy ? res[8*oidx +: 8] : 8'($urandom);
        end
    end

    // ---------------- response backpressure ----------------
    initial begin
        forever begin
            @(posedge CLK); #1;
            if (rand_bp) host.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic        prev_en, prev_rv;
        int          en_run, wait_start, m;
        logic [64:0] e;
        prev_en = 1'b0; prev_rv = 1'b0; en_run = 0; wait_start = 0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                en_run = 0;
            end else begin
                if (ENABLE) begin
                    if (!prev_en) check("gap_before_enable", (cyc - (hs_cyc + 1)) >= GAP + 1, 1);
                    en_run++;
                end else if (prev_en && en_run != 0) begin
                    check("enable_len", en_run, 16);
                    check("link_data_idle", LINK_DATA, 0);
                    en_run = 0;
                    wait_start = cyc;
                end
                if (host.rsp_valid && !prev_rv && exp_mode_q.size() > 0 && exp_mode_q[0] == M_NEVER)
                    check("timeout_cycles", cyc - wait_start, TIMEOUT);
                if (host.rsp_valid && host.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        m = exp_mode_q.pop_front();
                        check("rsp_data", host.rsp_data, e[63:0]);
                        check("rsp_err", host.rsp_err, e[64]);
                    end
                    hs_cyc = cyc;
                    rsp_cnt++;
                end
            end
            prev_en = ENABLE;
            prev_rv = host.rsp_valid;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [63:0] a, b, p;
        int          n0, k, low, mode;
        RESET = 1'b1;
        host.req_valid = 1'b0;
        host.op_a = 64'h0;
        host.op_b = 64'h0;
        host.rsp_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready", host.req_ready, 0);
        check("rst_enable", ENABLE, 0);
        check("rst_link_data", LINK_DATA, 0);
        check("rst_rsp_valid", host.rsp_valid, 0);
        check("rst_rsp_data", host.rsp_data, 0);
        check("rst_rsp_err", host.rsp_err, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Nominal 2.0 x 3.0
        n0 = rsp_cnt;
        send_req(64'h4000000000000000, 64'h4008000000000000, M_OK, 2, 0, 1'b1,
                 {1'b0, 64'h4018000000000000}, 1'b0);
        wait_rsp(n0 + 1);

        // Chip never answers
        run_txn(M_NEVER, 0, 0);

        // READY burst breaks after 3 bytes, then a normal transaction
        run_txn(M_BROKEN, 1, 3);
        run_txn(M_OK, 0, 0);

        // Response backpressure for 10 cycles
        @(posedge CLK); #1;
        host.rsp_ready = 1'b0;
        a = rand_double();
        b = rand_double();
        p = ref_prod(a, b);
        n0 = rsp_cnt;
        send_req(a, b, M_OK, 3, 0, 1'b1, {1'b0, p}, 1'b0);
        k = 0;
        while (!host.rsp_valid && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check("bp_rsp_valid", host.rsp_valid, 1);
        repeat (10) begin
            @(negedge CLK);
            check("bp_valid_hold", host.rsp_valid, 1);
            check("bp_data_hold", host.rsp_data, p);
            check("bp_req_ready", host.req_ready, 0);
        end
        @(posedge CLK); #1;
        host.rsp_ready = 1'b1;
        @(negedge CLK);
        low = 0;
        k = 0;
        while (k < 20) begin
            @(negedge CLK);
            if (host.req_ready) break;
            low++;
            k++;
        end
        check("gap_idle_cycles", low, GAP);
        check("bp_rsp_count", rsp_cnt, n0 + 1);

        // Reset in the middle of the operand burst, right after byte 5
        a = rand_double();
        b = rand_double();
        n0 = rsp_cnt;
        send_req(a, b, M_OK, 0, 0, 1'b0, 65'h0, 1'b0);
        repeat (5) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(negedge CLK);
        check("midsend_enable", ENABLE, 1);
        check("midsend_byte5", LINK_DATA, a[47:40]);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("reset_enable_low", ENABLE, 0);
        check("reset_rsp_valid", host.rsp_valid, 0);
        repeat (30) @(negedge CLK);
        check("no_rsp_after_reset", rsp_cnt, n0);
        run_txn(M_OK, 1, 0);

        // Back-to-back with req_valid held high
        a = rand_double();
        b = rand_double();
        n0 = rsp_cnt;
        send_req(a, b, M_OK, 0, 0, 1'b1, {1'b0, ref_prod(a, b)}, 1'b1);
        a = rand_double();
        b = rand_double();
        send_req(a, b, M_OK, 1, 0, 1'b1, {1'b0, ref_prod(a, b)}, 1'b0);
        wait_rsp(n0 + 2);

        // Randomised mix with random response backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 25; i++) begin
            k = $urandom_range(0, 9);
            mode = (k < 7) ? M_OK : ((k < 9) ? M_BROKEN : M_NEVER);
            run_txn(mode, $urandom_range(0, 10), $urandom_range(1, 7));
        end
        @(posedge CLK); #1;
        rand_bp = 1'b0;
        host.rsp_ready = 1'b1;

        repeat (10) @(negedge CLK);
        check("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
